// File: rtl/apb_master_mc.sv
// rtl/apb_master_mc.sv - APB4 master: command in, one-hot multi-slave transfer, one-cycle response pulse
// Optional stalled-transfer abort is compiled in with `define APB_TIMEOUT_EN.
module apb_master_mc #(
  parameter int ADDR_WIDTH     = 8,
  parameter int DATA_WIDTH     = 8,
  parameter int PSEL_WIDTH     = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                             PCLK_i,
  input  logic                             PRESET_i,
  input  logic                             CMD_VALID_i,
  output logic                             CMD_READY_o,
  input  logic                             CMD_WRITE_i,
  input  logic [ADDR_WIDTH-1:0]            CMD_ADDR_i,
  input  logic [PSEL_WIDTH-1:0]            CMD_SEL_i,
  input  logic [DATA_WIDTH-1:0]            CMD_WDATA_i,
  input  logic [DATA_WIDTH/8-1:0]          CMD_STRB_i,
  input  logic [2:0]                       CMD_PROT_i,
  output logic                             RSP_VALID_o,
  output logic [DATA_WIDTH-1:0]            RSP_RDATA_o,
  output logic                             RSP_ERR_o,
  output logic [ADDR_WIDTH-1:0]            PADDR_o,
  output logic                             PWRITE_o,
  output logic [PSEL_WIDTH-1:0]            PSEL_o,
  output logic                             PENABLE_o,
  output logic [DATA_WIDTH-1:0]            PWDATA_o,
  output logic [DATA_WIDTH/8-1:0]          PSTRB_o,
  output logic [2:0]                       PPROT_o,
  input  logic [PSEL_WIDTH-1:0]            PREADY_i,
  input  logic [PSEL_WIDTH-1:0]            PSLVERR_i,
  input  logic [PSEL_WIDTH*DATA_WIDTH-1:0] PRDATA_i
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, ERR} state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   paddr_q, paddr_d;
  logic                    pwrite_q, pwrite_d;
  logic [PSEL_WIDTH-1:0]   psel_q, psel_d;
  logic                    penable_q, penable_d;
  logic [DATA_WIDTH-1:0]   pwdata_q, pwdata_d;
  logic [STRB_WIDTH-1:0]   pstrb_q, pstrb_d;
  logic [2:0]              pprot_q, pprot_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                    rsp_err_q, rsp_err_d;

  logic                    pready_sel, pslverr_sel;
  logic [DATA_WIDTH-1:0]   prdata_sel;
  logic                    sel_onehot, cmd_ready, accept, done, timeout;

  // psel_q is one-hot whenever a transfer is live, so an OR-mux picks the target slave
  always_comb begin
    pready_sel  = 1'b0;
    pslverr_sel = 1'b0;
    prdata_sel  = '0;
    for (int k = 0; k < PSEL_WIDTH; k++) begin
      if (psel_q[k]) begin
        pready_sel  = pready_sel | PREADY_i[k];
        pslverr_sel = pslverr_sel | PSLVERR_i[k];
        prdata_sel  = prdata_sel | PRDATA_i[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign sel_onehot = $onehot(CMD_SEL_i);
  assign done       = (state_q == ACCESS) && pready_sel;
  assign cmd_ready  = !PRESET_i && ((state_q == IDLE) || done);
  assign accept     = CMD_VALID_i && cmd_ready;

`ifdef APB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = '0;
    if ((state_q == ACCESS) && !pready_sel) cnt_d = cnt_q + CNT_W'(1);
  end

  assign timeout = (state_q == ACCESS) && !pready_sel &&
                   (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge PCLK_i) begin
    if (PRESET_i) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
  assign timeout = 1'b0;
`endif

  always_ff @(posedge PCLK_i) begin
    if (PRESET_i) begin
      state_q     <= IDLE;
      paddr_q     <= '0;
      pwrite_q    <= 1'b0;
      psel_q      <= '0;
      penable_q   <= 1'b0;
      pwdata_q    <= '0;
      pstrb_q     <= '0;
      pprot_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      paddr_q     <= paddr_d;
      pwrite_q    <= pwrite_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwdata_q    <= pwdata_d;
      pstrb_q     <= pstrb_d;
      pprot_q     <= pprot_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = sel_onehot ? SETUP : ERR;
      SETUP:   state_d = ACCESS;
      ACCESS: begin
        if (done)         state_d = accept ? (sel_onehot ? SETUP : ERR) : IDLE;
        else if (timeout) state_d = IDLE;
      end
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    paddr_d     = paddr_q;
    pwrite_d    = pwrite_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwdata_d    = pwdata_q;
    pstrb_d     = pstrb_q;
    pprot_d     = pprot_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = '0;
    rsp_err_d   = 1'b0;
    case (state_q)
      SETUP: penable_d = 1'b1;
      ACCESS: begin
        if (done) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = pslverr_sel;
          rsp_rdata_d = pwrite_q ? '0 : prdata_sel;
          psel_d      = '0;
          penable_d   = 1'b0;
        end else if (timeout) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          psel_d      = '0;
          penable_d   = 1'b0;
        end
      end
      ERR: begin
        rsp_valid_d = 1'b1;
        rsp_err_d   = 1'b1;
      end
      default: ;
    endcase
    // A bad select still latches the fields but never raises PSEL
    if (accept) begin
      paddr_d   = CMD_ADDR_i;
      pwrite_d  = CMD_WRITE_i;
      pwdata_d  = CMD_WRITE_i ? CMD_WDATA_i : '0;
      pstrb_d   = CMD_WRITE_i ? CMD_STRB_i : '0;
      pprot_d   = CMD_PROT_i;
      psel_d    = sel_onehot ? CMD_SEL_i : '0;
      penable_d = 1'b0;
    end
  end

  assign CMD_READY_o = cmd_ready;
  assign RSP_VALID_o = rsp_valid_q;
  assign RSP_RDATA_o = rsp_rdata_q;
  assign RSP_ERR_o   = rsp_err_q;
  assign PADDR_o     = paddr_q;
  assign PWRITE_o    = pwrite_q;
  assign PSEL_o      = psel_q;
  assign PENABLE_o   = penable_q;
  assign PWDATA_o    = pwdata_q;
  assign PSTRB_o     = pstrb_q;
  assign PPROT_o     = pprot_q;

endmodule

// File: tb/tb_apb_master_mc.sv
// tb/tb_apb_master_mc.sv - self-checking bench for apb_master_mc
module tb_apb_master_mc;
  localparam int DW  = 8;
  localparam int PW  = 4;
  localparam int TMO = 16;

  logic        PCLK_i = 1'b0;
  logic        PRESET_i;
  logic        CMD_VALID_i, CMD_WRITE_i;
  logic [7:0]  CMD_ADDR_i, CMD_WDATA_i;
  logic [3:0]  CMD_SEL_i;
  logic [0:0]  CMD_STRB_i;
  logic [2:0]  CMD_PROT_i;
  logic        CMD_READY_o, RSP_VALID_o, RSP_ERR_o, PWRITE_o, PENABLE_o;
  logic [7:0]  RSP_RDATA_o, PADDR_o, PWDATA_o;
  logic [3:0]  PSEL_o;
  logic [0:0]  PSTRB_o;
  logic [2:0]  PPROT_o;
  logic [3:0]  PREADY_i = '0;
  logic [3:0]  PSLVERR_i = '0;
  logic [31:0] PRDATA_i = '0;

  apb_master_mc #(.ADDR_WIDTH(8), .DATA_WIDTH(DW), .PSEL_WIDTH(PW), .TIMEOUT_CYCLES(TMO)) dut (
    .PCLK_i(PCLK_i), .PRESET_i(PRESET_i),
    .CMD_VALID_i(CMD_VALID_i), .CMD_READY_o(CMD_READY_o), .CMD_WRITE_i(CMD_WRITE_i),
    .CMD_ADDR_i(CMD_ADDR_i), .CMD_SEL_i(CMD_SEL_i), .CMD_WDATA_i(CMD_WDATA_i),
    .CMD_STRB_i(CMD_STRB_i), .CMD_PROT_i(CMD_PROT_i),
    .RSP_VALID_o(RSP_VALID_o), .RSP_RDATA_o(RSP_RDATA_o), .RSP_ERR_o(RSP_ERR_o),
    .PADDR_o(PADDR_o), .PWRITE_o(PWRITE_o), .PSEL_o(PSEL_o), .PENABLE_o(PENABLE_o),
    .PWDATA_o(PWDATA_o), .PSTRB_o(PSTRB_o), .PPROT_o(PPROT_o),
    .PREADY_i(PREADY_i), .PSLVERR_i(PSLVERR_i), .PRDATA_i(PRDATA_i)
  );

  always #5 PCLK_i = ~PCLK_i;

  typedef struct {
    logic       w;
    logic [7:0] a;
    logic [3:0] s;
    logic [7:0] wd;
    logic [0:0] st;
    logic [2:0] pr;
    int         nw;
    logic       serr;
    bit         bad;
    logic [7:0] erd;
    logic       eerr;
  } vec_t;

  typedef struct {
    logic       w;
    logic [7:0] a;
    logic [3:0] s;
    logic [7:0] wd;
    logic [0:0] st;
    logic [2:0] pr;
    bit         bad;
    int         lat;
    int         nw;
    logic [7:0] rd;
    logic       er;
    int         acc_cyc;
  } sb_t;

  int   n_pass = 0;
  int   n_total = 0;
  int   cyc = 0;
  sb_t  sb_q[$];
  sb_t  mon_e;
  bit   mon_en = 1'b0;
  int   sel_cnt = 0;
  int   en_cnt = 0;
  logic [7:0] slv_mem [256];
  int   slv_wait = 0;
  logic slv_err = 1'b0;
  int   slv_wcnt = 0;
  bit   b2b_arm = 1'b0;
  bit   b2b_active = 1'b0;
  int   b2b_rsp = 0;
  int   b2b_drops = 0;
  int   last_rsp_cyc = 0;
  vec_t vecs [8];

  always @(posedge PCLK_i) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic [63:0] all_outs();
    return {27'b0, CMD_READY_o, RSP_VALID_o, RSP_RDATA_o, RSP_ERR_o, PADDR_o, PWRITE_o,
            PSEL_o, PENABLE_o, PWDATA_o, PSTRB_o, PPROT_o};
  endfunction

  // Monitor/scoreboard followed by the APB slave model, all on the falling edge
  always @(negedge PCLK_i) begin
    if (mon_en) begin
      if (RSP_VALID_o) begin
        if (sb_q.size() == 0) begin
          check("rsp_valid_unexpected", RSP_VALID_o, 1'b0);
        end else begin
          mon_e = sb_q.pop_front();
          check("rsp_rdata", RSP_RDATA_o, mon_e.rd);
          check("rsp_err", RSP_ERR_o, mon_e.er);
          if (mon_e.lat >= 0) check("rsp_latency", cyc - mon_e.acc_cyc, mon_e.lat);
          if (mon_e.bad) begin
            check("bad_sel_psel_cycles", sel_cnt, 0);
          end else if (mon_e.lat >= 0) begin
            check("penable_cycles", en_cnt, mon_e.nw + 1);
            check("psel_cycles", sel_cnt, mon_e.nw + 2);
          end
          if (b2b_arm) begin
            if (b2b_rsp > 0) check("b2b_rsp_spacing", cyc - last_rsp_cyc, 2);
            last_rsp_cyc = cyc;
            b2b_rsp++;
            if (b2b_rsp == 7) b2b_active = 1'b0;
          end
        end
        sel_cnt = 0;
        en_cnt  = 0;
      end
      if (PSEL_o != '0) begin
        if (sb_q.size() == 0) begin
          check("psel_unexpected", PSEL_o, 4'b0);
        end else begin
          mon_e = sb_q[0];
          check("apb_fields", {PSEL_o, PADDR_o, PWRITE_o, PWDATA_o, PSTRB_o, PPROT_o},
                {mon_e.s, mon_e.a, mon_e.w, (mon_e.w ? mon_e.wd : 8'h00),
                 (mon_e.w ? mon_e.st : 1'b0), mon_e.pr});
          check("penable_phase", PENABLE_o, (sel_cnt != 0));
        end
        sel_cnt++;
        if (PENABLE_o) en_cnt++;
      end else if (b2b_active) begin
        b2b_drops++;
      end
      if (b2b_arm && b2b_rsp == 0 && PSEL_o != '0) b2b_active = 1'b1;
    end else begin
      sel_cnt = 0;
      en_cnt  = 0;
    end

    // Unselected slaves present hostile values so a wrong mux shows up
    for (int k = 0; k < PW; k++) begin
      PREADY_i[k]          = 1'b1;
      PSLVERR_i[k]         = 1'b1;
      PRDATA_i[k*DW +: DW] = 8'hE0 + 8'(k);
    end
    if (PSEL_o == '0 || !PENABLE_o) slv_wcnt = 0;
    for (int k = 0; k < PW; k++) begin
      if (PSEL_o[k]) begin
        PSLVERR_i[k]         = slv_err;
        PRDATA_i[k*DW +: DW] = slv_mem[PADDR_o];
        if (PENABLE_o && slv_wcnt < slv_wait) begin
          PREADY_i[k] = 1'b0;
          slv_wcnt++;
        end else begin
          PREADY_i[k] = PENABLE_o;
        end
      end
    end
  end

  // Call on a falling edge; returns just after the accepting rising edge
  task automatic send_cmd(input logic w, input logic [7:0] a, input logic [3:0] s,
                          input logic [7:0] wd, input logic [0:0] st, input logic [2:0] pr,
                          input bit bad, input int lat, input int nw,
                          input logic [7:0] rd, input logic er, output int acc);
    sb_t e;
    bit  ok = 1'b0;
    acc = cyc;
    CMD_VALID_i = 1'b1; CMD_WRITE_i = w; CMD_ADDR_i = a; CMD_SEL_i = s;
    CMD_WDATA_i = wd; CMD_STRB_i = st; CMD_PROT_i = pr;
    for (int i = 0; i < 64 && !ok; i++) begin
      #4;
      if (CMD_READY_o) begin
        e.w = w; e.a = a; e.s = s; e.wd = wd; e.st = st; e.pr = pr; e.bad = bad;
        e.lat = lat; e.nw = nw; e.rd = rd; e.er = er; e.acc_cyc = cyc;
        acc = cyc;
        sb_q.push_back(e);
        ok = 1'b1;
        @(posedge PCLK_i);
      end else begin
        @(negedge PCLK_i);
      end
    end
    if (!ok) check("cmd_accept_timeout", CMD_READY_o, 1'b1);
  endtask

  task automatic wait_rsp();
    for (int i = 0; i < 300 && sb_q.size() != 0; i++) @(negedge PCLK_i);
    if (sb_q.size() != 0) begin
      check("rsp_wait_timeout", sb_q.size(), 0);
      sb_q.delete();
    end
  endtask

  initial begin
    int acc;
    PRESET_i = 1'b1;
    CMD_VALID_i = 1'b0; CMD_WRITE_i = 1'b0; CMD_ADDR_i = '0; CMD_SEL_i = '0;
    CMD_WDATA_i = '0; CMD_STRB_i = '0; CMD_PROT_i = '0;
    for (int i = 0; i < 256; i++) slv_mem[i] = 8'(i * 7 + 3);
    slv_mem[8'h15] = 8'h28; slv_mem[8'h30] = 8'h5A; slv_mem[8'hFF] = 8'hC3;
    slv_mem[8'h04] = 8'h99; slv_mem[8'h31] = 8'h77;
    slv_mem[1] = 8'h72; slv_mem[2] = 8'h66; slv_mem[3] = 8'h09; slv_mem[4] = 8'h87;
    slv_mem[5] = 8'h44; slv_mem[6] = 8'h54; slv_mem[7] = 8'h00;

    //          w     addr   sel      wdata  st    prot  nw serr  bad erd    eerr
    vecs[0] = '{1'b0, 8'h15, 4'b0010, 8'h3C, 1'b1, 3'd0, 0, 1'b0, 0, 8'h28, 1'b0};
    vecs[1] = '{1'b1, 8'h04, 4'b0001, 8'hA5, 1'b1, 3'd2, 3, 1'b0, 0, 8'h00, 1'b0};
    vecs[2] = '{1'b0, 8'h30, 4'b0100, 8'h00, 1'b0, 3'd1, 0, 1'b1, 0, 8'h5A, 1'b1};
    vecs[3] = '{1'b1, 8'h31, 4'b1000, 8'h6E, 1'b0, 3'd7, 1, 1'b1, 0, 8'h00, 1'b1};
    vecs[4] = '{1'b1, 8'h22, 4'b0110, 8'h11, 1'b1, 3'd0, 0, 1'b0, 1, 8'h00, 1'b1};
    vecs[5] = '{1'b0, 8'h23, 4'b0000, 8'h00, 1'b0, 3'd0, 0, 1'b0, 1, 8'h00, 1'b1};
    vecs[6] = '{1'b0, 8'hFF, 4'b1000, 8'h5F, 1'b1, 3'd5, 2, 1'b0, 0, 8'hC3, 1'b0};
    vecs[7] = '{1'b0, 8'h15, 4'b1111, 8'h00, 1'b0, 3'd0, 0, 1'b0, 1, 8'h00, 1'b1};

    repeat (3) @(negedge PCLK_i);
    check("reset_outputs", all_outs(), 64'h0);
    PRESET_i = 1'b0;
    #1 check("ready_after_reset", CMD_READY_o, 1'b1);
    mon_en = 1'b1;
    @(negedge PCLK_i);

    for (int i = 0; i < 8; i++) begin
      slv_wait = vecs[i].nw;
      slv_err  = vecs[i].serr;
      send_cmd(vecs[i].w, vecs[i].a, vecs[i].s, vecs[i].wd, vecs[i].st, vecs[i].pr,
               vecs[i].bad, vecs[i].bad ? 2 : 3 + vecs[i].nw, vecs[i].nw,
               vecs[i].erd, vecs[i].eerr, acc);
      @(negedge PCLK_i);
      CMD_VALID_i = 1'b0;
      wait_rsp();
      @(negedge PCLK_i);
    end

    // Back-to-back reads with CMD_VALID_i held high
    slv_wait = 0; slv_err = 1'b0; b2b_arm = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      send_cmd(1'b0, 8'(i), 4'b0001, 8'h00, 1'b0, 3'd0, 0, 3, 0, slv_mem[i], 1'b0, acc);
      @(negedge PCLK_i);
    end
    CMD_VALID_i = 1'b0;
    wait_rsp();
    check("b2b_rsp_count", b2b_rsp, 7);
    check("b2b_psel_drops", b2b_drops, 0);
    b2b_arm = 1'b0;
    @(negedge PCLK_i);

    // Slave never ready
    slv_wait = 100000;
`ifdef APB_TIMEOUT_EN
    send_cmd(1'b0, 8'h15, 4'b0010, 8'h00, 1'b0, 3'd0, 0, TMO + 2, TMO - 1, 8'h00, 1'b1, acc);
    @(negedge PCLK_i);
    CMD_VALID_i = 1'b0;
    wait_rsp();
    check("idle_after_timeout", {PSEL_o, PENABLE_o}, 5'b0);
`else
    send_cmd(1'b0, 8'h15, 4'b0010, 8'h00, 1'b0, 3'd0, 0, -1, -1, 8'h28, 1'b0, acc);
    @(negedge PCLK_i);
    CMD_VALID_i = 1'b0;
    while (cyc - acc < 100) @(negedge PCLK_i);
    check("penable_at_cycle_100", PENABLE_o, 1'b1);
    check("no_rsp_while_stalled", sb_q.size(), 1);
    slv_wait = 0;
    wait_rsp();
`endif
    slv_wait = 0;
    @(negedge PCLK_i);

    // Reset during an ACCESS wait state
    slv_wait = 100000;
    send_cmd(1'b0, 8'h40, 4'b0001, 8'h00, 1'b0, 3'd3, 0, -1, -1, 8'h00, 1'b0, acc);
    @(negedge PCLK_i);
    CMD_VALID_i = 1'b0;
    repeat (2) @(negedge PCLK_i);
    check("penable_before_reset", PENABLE_o, 1'b1);
    mon_en = 1'b0;
    PRESET_i = 1'b1;
    #4 check("ready_during_reset", CMD_READY_o, 1'b0);
    @(negedge PCLK_i);
    check("outputs_after_mid_reset", all_outs(), 64'h0);
    PRESET_i = 1'b0;
    sb_q.delete();
    slv_wait = 0;
    @(negedge PCLK_i);
    mon_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("no_rsp_after_reset", RSP_VALID_o, 1'b0);
      @(negedge PCLK_i);
    end
    send_cmd(1'b0, 8'h15, 4'b0010, 8'h00, 1'b0, 3'd0, 0, 3, 0, 8'h28, 1'b0, acc);
    @(negedge PCLK_i);
    CMD_VALID_i = 1'b0;
    wait_rsp();
    repeat (2) @(negedge PCLK_i);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_total);
    $fatal(1, "watchdog");
  end

endmodule
